// File: rtl/user_def_accel_pkg.sv
// Shared types and constants for the accelerator dispatch block.
package user_def_accel_pkg;

  localparam int FUNC_ID_W  = 10;
  localparam int DATA_W     = 32;
  localparam int MAX_SLOTS  = 4;
  localparam int SLOT_IDX_W = 2;

  // Returned in place of real data for unmapped commands and timed-out slots.
  localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

  // One entry per accepted command, remembering where its response comes from.
  typedef struct packed {
    logic                  unmapped;
    logic [SLOT_IDX_W-1:0] slot;
  } tag_t;

  // True when a decoded select value falls inside the window of attached slots.
  function automatic logic sel_in_window(input int sel, input int base, input int num);
    return (sel >= base) && (sel < base + num);
  endfunction

endpackage

// File: rtl/user_def_accel_tag_fifo.sv
// Small register-based FIFO holding the tags of outstanding commands.
// The head entry is visible combinationally so the response path adds no latency.
module user_def_accel_tag_fifo
  import user_def_accel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  tag_t                     i_data,
  input  logic                     i_pop,
  output tag_t                     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  tag_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push & (r_count != (AW+1)'(DEPTH));
  assign w_pop  = i_pop  & (r_count != '0);

  // Storage array; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/user_def_accel_dispatch.sv
// Dispatches custom-instruction commands to one of several accelerator slots
// and returns their responses strictly in command order. Unmapped commands
// and slots that stay silent too long are answered with ERR_DATA.
module user_def_accel_dispatch
  import user_def_accel_pkg::*;
#(
  parameter int NUM_SLOTS       = 2,
  parameter int SLOT_SEL_LSB    = 5,
  parameter int SLOT_SEL_W      = 2,
  parameter int SLOT_BASE       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // Command from the CPU
  input  logic                          cmd_valid,
  input  logic [FUNC_ID_W-1:0]          cmd_function_id,
  input  logic [DATA_W-1:0]             cmd_inputs_0,
  input  logic [DATA_W-1:0]             cmd_inputs_1,
  output logic                          cmd_ready,
  // Response to the CPU
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_outputs_0,
  input  logic                          rsp_ready,
  // Command fan-out to slots (payload broadcast)
  output logic [NUM_SLOTS-1:0]          slot_cmd_valid,
  input  logic [NUM_SLOTS-1:0]          slot_cmd_ready,
  output logic [FUNC_ID_W-1:0]          slot_cmd_function_id,
  output logic [DATA_W-1:0]             slot_cmd_inputs_0,
  output logic [DATA_W-1:0]             slot_cmd_inputs_1,
  // Responses from slots
  input  logic [NUM_SLOTS-1:0]          slot_rsp_valid,
  input  logic [DATA_W*NUM_SLOTS-1:0]   slot_rsp_outputs_0,
  output logic [NUM_SLOTS-1:0]          slot_rsp_ready,
  // Status
  output logic                          busy,
  output logic                          err_unmapped,
  output logic                          err_timeout
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [SLOT_SEL_W-1:0] w_sel;
  logic                  w_cmd_mapped;
  logic [SLOT_IDX_W-1:0] w_cmd_slot;
  logic [NUM_SLOTS-1:0]  w_cmd_oh;
  logic                  w_cmd_slot_ok;

  assign w_sel = cmd_function_id[SLOT_SEL_LSB +: SLOT_SEL_W];

  // Map the select field onto a slot index and a one-hot slot vector.
  always_comb begin
    w_cmd_mapped = sel_in_window(int'(w_sel), SLOT_BASE, NUM_SLOTS);
    w_cmd_slot   = '0;
    w_cmd_oh     = '0;
    if (w_cmd_mapped) begin
      w_cmd_slot = SLOT_IDX_W'(int'(w_sel) - SLOT_BASE);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_cmd_oh[i] = w_cmd_mapped && (w_cmd_slot == SLOT_IDX_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  tag_t             w_push_tag;
  tag_t             w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  assign w_push_tag = '{unmapped: ~w_cmd_mapped, slot: w_cmd_slot};

  user_def_accel_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_tag),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------------------
  // Command handshake
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] r_discard;

  // Only the addressed slot's ready matters; a slot still draining a stale
  // response is treated as not ready so new commands cannot overtake it.
  assign w_cmd_slot_ok  = |(w_cmd_oh & slot_cmd_ready & ~r_discard);
  assign cmd_ready      = reset_n & ~w_full & (~w_cmd_mapped | w_cmd_slot_ok);
  assign slot_cmd_valid = {NUM_SLOTS{reset_n & cmd_valid & ~w_full}} & w_cmd_oh & ~r_discard;
  assign w_push         = cmd_valid & cmd_ready;

  assign slot_cmd_function_id = cmd_function_id;
  assign slot_cmd_inputs_0    = cmd_inputs_0;
  assign slot_cmd_inputs_1    = cmd_inputs_1;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  logic                 w_head_mapped;
  logic [NUM_SLOTS-1:0] w_head_oh;
  logic                 w_head_rsp_valid;
  logic [DATA_W-1:0]    w_head_rsp_data;
  logic                 w_timed_out;
  logic                 w_rsp_valid;
  logic [TO_W-1:0]      r_to_cnt;

  assign w_head_mapped = ~w_empty & ~w_head.unmapped;

  // Select the head slot's response; a slot being drained never feeds the CPU.
  always_comb begin
    w_head_oh       = '0;
    w_head_rsp_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_head_oh[i] = w_head_mapped && (w_head.slot == SLOT_IDX_W'(i));
      if (w_head_oh[i]) begin
        w_head_rsp_data = slot_rsp_outputs_0[i*DATA_W +: DATA_W];
      end
    end
    w_head_rsp_valid = |(w_head_oh & slot_rsp_valid & ~r_discard);
  end

  assign w_timed_out = (TIMEOUT != 0) && w_head_mapped && (r_to_cnt == TO_W'(TIMEOUT));

  // Unmapped or timed-out heads are answered locally with ERR_DATA.
  always_comb begin
    w_rsp_valid   = 1'b0;
    rsp_outputs_0 = '0;
    if (reset_n && !w_empty) begin
      if (w_head.unmapped || w_timed_out) begin
        w_rsp_valid   = 1'b1;
        rsp_outputs_0 = ERR_DATA;
      end else if (w_head_rsp_valid) begin
        w_rsp_valid   = 1'b1;
        rsp_outputs_0 = w_head_rsp_data;
      end
    end
  end

  assign rsp_valid = w_rsp_valid;
  assign w_pop     = w_rsp_valid & rsp_ready;

  // Head slot sees the CPU's ready (withheld once the head has timed out);
  // draining slots are always ready so the stale response is swallowed.
  assign slot_rsp_ready = {NUM_SLOTS{reset_n}} &
                          ((w_head_oh & ~r_discard & {NUM_SLOTS{rsp_ready & ~w_timed_out}}) |
                           r_discard);

  // Timeout counter: the head can only change on a pop or when the FIFO leaves
  // the empty state, and the counter is zero in both cases, so clearing on pop
  // and while no mapped head exists covers every head change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (w_pop || !w_head_mapped) begin
      r_to_cnt <= '0;
    end else if ((TIMEOUT != 0) && !w_head_rsp_valid && (r_to_cnt != TO_W'(TIMEOUT))) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot discard flags
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] w_discard_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      // A timeout pop arms the drain (taking priority, since the head's own
      // response is still owed); a response seen while armed disarms it.
      assign w_discard_next[gi] = (w_pop && w_timed_out && w_head_oh[gi]) ? 1'b1 :
                                  (r_discard[gi] && slot_rsp_valid[gi])    ? 1'b0 :
                                  r_discard[gi];
    end
  endgenerate

  // Discard flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_discard <= '0;
    end else begin
      r_discard <= w_discard_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (w_push && !w_cmd_mapped) begin
        err_unmapped <= 1'b1;
      end
      if (w_timed_out) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign busy = (w_count != '0);

endmodule

// File: tb/tb_user_def_accel_dispatch.sv
// Directed bench for the accelerator dispatcher: two slots, short timeout.
module tb_user_def_accel_dispatch;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_outputs_0;
  logic        rsp_ready;
  logic [1:0]  slot_cmd_valid;
  logic [1:0]  slot_cmd_ready;
  logic [9:0]  slot_cmd_function_id;
  logic [31:0] slot_cmd_inputs_0;
  logic [31:0] slot_cmd_inputs_1;
  logic [1:0]  slot_rsp_valid;
  logic [63:0] slot_rsp_outputs_0;
  logic [1:0]  slot_rsp_ready;
  logic        busy;
  logic        err_unmapped;
  logic        err_timeout;

  int n_checks;
  int n_fail;

  user_def_accel_dispatch #(
    .NUM_SLOTS       (2),
    .SLOT_SEL_LSB    (5),
    .SLOT_SEL_W      (2),
    .SLOT_BASE       (2),
    .MAX_OUTSTANDING (4),
    .TIMEOUT         (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .cmd_valid            (cmd_valid),
    .cmd_function_id      (cmd_function_id),
    .cmd_inputs_0         (cmd_inputs_0),
    .cmd_inputs_1         (cmd_inputs_1),
    .cmd_ready            (cmd_ready),
    .rsp_valid            (rsp_valid),
    .rsp_outputs_0        (rsp_outputs_0),
    .rsp_ready            (rsp_ready),
    .slot_cmd_valid       (slot_cmd_valid),
    .slot_cmd_ready       (slot_cmd_ready),
    .slot_cmd_function_id (slot_cmd_function_id),
    .slot_cmd_inputs_0    (slot_cmd_inputs_0),
    .slot_cmd_inputs_1    (slot_cmd_inputs_1),
    .slot_rsp_valid       (slot_rsp_valid),
    .slot_rsp_outputs_0   (slot_rsp_outputs_0),
    .slot_rsp_ready       (slot_rsp_ready),
    .busy                 (busy),
    .err_unmapped         (err_unmapped),
    .err_timeout          (err_timeout)
  );

  always #5 clk = ~clk;

  task test_reset;
    reset_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_function_id = 10'h000;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (slot_cmd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_slot_cmd_valid: got %b expected 00", slot_cmd_valid); end
    n_checks++; if (slot_rsp_ready !== 2'b00) begin n_fail++; $display("FAIL reset_slot_rsp_ready: got %b expected 00", slot_rsp_ready); end
    n_checks++; if (err_unmapped !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_errs: got %b%b expected 00", err_unmapped, err_timeout); end
    @(negedge clk);
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    $display("reset: checks done");
  endtask

  task test_mapped;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h040; cmd_inputs_0 = 32'h0000_1234; cmd_inputs_1 = 32'h0000_5678;
    slot_cmd_ready = 2'b11;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL map_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (slot_cmd_valid !== 2'b01) begin n_fail++; $display("FAIL map_slot_cmd_valid: got %b expected 01", slot_cmd_valid); end
    n_checks++; if (slot_cmd_inputs_0 !== 32'h0000_1234 || slot_cmd_function_id !== 10'h040) begin n_fail++; $display("FAIL map_broadcast: got %h/%h expected 00001234/040", slot_cmd_inputs_0, slot_cmd_function_id); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0, 32'h0000_0005};
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL map_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_outputs_0 !== 32'h0000_0005) begin n_fail++; $display("FAIL map_rsp_data: got %h expected 00000005", rsp_outputs_0); end
    n_checks++; if (slot_rsp_ready !== 2'b01) begin n_fail++; $display("FAIL map_slot_rsp_ready: got %b expected 01", slot_rsp_ready); end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL map_busy_after: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_outputs_0 !== 32'h0) begin n_fail++; $display("FAIL map_idle_rsp: got %b/%h expected 0/00000000", rsp_valid, rsp_outputs_0); end
    $display("mapped: fid=040 rsp=%h", 32'h5);
  endtask

  task test_unmapped;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h000; slot_cmd_ready = 2'b00; rsp_ready = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL unm_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (slot_cmd_valid !== 2'b00) begin n_fail++; $display("FAIL unm_slot_cmd_valid: got %b expected 00", slot_cmd_valid); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL unm_rsp_early: got %b expected 0", rsp_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unm_rsp: got %b/%h expected 1/deadbeef", rsp_valid, rsp_outputs_0); end
    n_checks++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unm_err: got %b expected 1", err_unmapped); end
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unm_after: got busy=%b err=%b expected 0/1", busy, err_unmapped); end
    slot_cmd_ready = 2'b11;
    $display("unmapped: fid=000 rsp=deadbeef");
  endtask

  task test_ordering;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h060; rsp_ready = 1'b0;
    #1;
    n_checks++; if (slot_cmd_valid !== 2'b10) begin n_fail++; $display("FAIL ord_cmd1: got %b expected 10", slot_cmd_valid); end
    @(negedge clk);
    cmd_function_id = 10'h040;
    #1;
    n_checks++; if (slot_cmd_valid !== 2'b01) begin n_fail++; $display("FAIL ord_cmd0: got %b expected 01", slot_cmd_valid); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0000_00B1, 32'h0000_00A0};
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ord_hold_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (slot_rsp_ready !== 2'b10) begin n_fail++; $display("FAIL ord_hold_ready: got %b expected 10", slot_rsp_ready); end
    @(negedge clk);
    slot_rsp_valid = 2'b11;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h0000_00B1) begin n_fail++; $display("FAIL ord_first: got %b/%h expected 1/000000b1", rsp_valid, rsp_outputs_0); end
    n_checks++; if (slot_rsp_ready !== 2'b10) begin n_fail++; $display("FAIL ord_first_ready: got %b expected 10", slot_rsp_ready); end
    @(negedge clk);
    slot_rsp_valid = 2'b01;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h0000_00A0) begin n_fail++; $display("FAIL ord_second: got %b/%h expected 1/000000a0", rsp_valid, rsp_outputs_0); end
    n_checks++; if (slot_rsp_ready !== 2'b01) begin n_fail++; $display("FAIL ord_second_ready: got %b expected 01", slot_rsp_ready); end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ord_busy: got %b expected 0", busy); end
    $display("ordering: slot1 then slot0 delivered in order");
  endtask

  task test_full;
    rsp_ready = 1'b0; slot_rsp_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_function_id = 10'h040; cmd_inputs_0 = k;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %b expected 1", k, cmd_ready); end
    end
    @(negedge clk);
    cmd_inputs_0 = 32'd4;
    #1;
    n_checks++; if (cmd_ready !== 1'b0 || slot_cmd_valid !== 2'b00) begin n_fail++; $display("FAIL full_stall: got ready=%b scv=%b expected 0/00", cmd_ready, slot_cmd_valid); end
    @(negedge clk);
    rsp_ready = 1'b1; slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0, 32'h0000_0010};
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_same: got rsp_valid=%b cmd_ready=%b expected 1/0", rsp_valid, cmd_ready); end
    @(negedge clk);
    rsp_ready = 1'b0; slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept5: got %b expected 1", cmd_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; rsp_ready = 1'b1; slot_rsp_valid = 2'b01;
      slot_rsp_outputs_0 = {32'h0, 32'h0000_0020 + k};
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h0000_0020 + k) begin n_fail++; $display("FAIL full_drain%0d: got %b/%h expected 1/%h", k, rsp_valid, rsp_outputs_0, 32'h20 + k); end
    end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", busy); end
    $display("full: 4 accepted, 5th stalled then accepted, 5 responses");
  endtask

  task test_timeout;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h040; rsp_ready = 1'b1; slot_rsp_valid = 2'b00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_quiet%0d: got %b expected 0", k, rsp_valid); end
    end
    @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_err_data: got %b/%h expected 1/deadbeef", rsp_valid, rsp_outputs_0); end
    n_checks++; if (slot_rsp_ready !== 2'b00) begin n_fail++; $display("FAIL to_ready_hold: got %b expected 00", slot_rsp_ready); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h040;
    slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0, 32'h0000_0077};
    #1;
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_err_flag: got %b expected 1", err_timeout); end
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_drop: got busy=%b rsp_valid=%b expected 0/0", busy, rsp_valid); end
    n_checks++; if (slot_rsp_ready !== 2'b01) begin n_fail++; $display("FAIL to_discard_ready: got %b expected 01", slot_rsp_ready); end
    n_checks++; if (cmd_ready !== 1'b0 || slot_cmd_valid !== 2'b00) begin n_fail++; $display("FAIL to_stall: got ready=%b scv=%b expected 0/00", cmd_ready, slot_cmd_valid); end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (cmd_ready !== 1'b1 || slot_cmd_valid !== 2'b01) begin n_fail++; $display("FAIL to_resume: got ready=%b scv=%b expected 1/01", cmd_ready, slot_cmd_valid); end
    @(negedge clk);
    cmd_valid = 1'b0; slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0, 32'h0000_0099};
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h0000_0099) begin n_fail++; $display("FAIL to_next_rsp: got %b/%h expected 1/00000099", rsp_valid, rsp_outputs_0); end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b expected 0", busy); end
    $display("timeout: err at cycle 16, late rsp dropped, next cmd served");
  endtask

  task test_reset_mid;
    rsp_ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b1; cmd_function_id = 10'h000;
    @(negedge clk); cmd_function_id = 10'h040;
    @(negedge clk); cmd_function_id = 10'h060;
    @(negedge clk); cmd_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got busy=%b rsp_valid=%b expected 1/1", busy, rsp_valid); end
    n_checks++; if (err_unmapped !== 1'b1 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_errs: got %b%b expected 11", err_unmapped, err_timeout); end
    #1;
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_function_id = 10'h000;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got busy=%b rsp_valid=%b expected 0/0", busy, rsp_valid); end
    n_checks++; if (err_unmapped !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL rmid_errs: got %b%b expected 00", err_unmapped, err_timeout); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_cmd_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    reset_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_function_id = 10'h040;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after_cmd: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1; slot_rsp_valid = 2'b01; slot_rsp_outputs_0 = {32'h0, 32'h0000_0042};
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h0000_0042) begin n_fail++; $display("FAIL rmid_after_rsp: got %b/%h expected 1/00000042", rsp_valid, rsp_outputs_0); end
    @(negedge clk);
    slot_rsp_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_final_busy: got %b expected 0", busy); end
    $display("reset_mid: 3 outstanding dropped, recovery ok");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk = 1'b0;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_function_id = '0;
    cmd_inputs_0 = '0;
    cmd_inputs_1 = '0;
    rsp_ready = 1'b0;
    slot_cmd_ready = 2'b00;
    slot_rsp_valid = 2'b00;
    slot_rsp_outputs_0 = '0;
    test_reset;
    test_mapped;
    test_unmapped;
    test_ordering;
    test_full;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
